// File: rtl/seg7_display_reader.sv
// Reads four cascaded 7-segment LED buses back into a 16-bit hex value.
// Each digit must hold one pattern for STABLE samples before it is decoded.
module seg7_display_reader #(
  parameter int STABLE    = 2,
  parameter int MAX_TRIES = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Type,
  input  logic        En,
  input  logic        Start,
  input  logic [0:7]  LED1,
  input  logic [0:7]  LED2,
  input  logic [0:7]  LED3,
  input  logic [0:7]  LED4,
  input  logic        Ready,
  output logic [15:0] Value,
  output logic [3:0]  DP,
  output logic [3:0]  Blank,
  output logic [3:0]  Err,
  output logic        Valid,
  output logic        Busy,
  output logic [1:0]  o_dbg_state
);

  // Handshake: the result is presented when Valid is high and is held, frozen,
  // until the edge on which Valid and Ready are both high; Valid then drops.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int MW = $clog2(STABLE + 1);
  localparam logic [TW-1:0] L_MAX    = TW'(MAX_TRIES);
  localparam logic [MW-1:0] L_STABLE = MW'(STABLE);

  logic [1:0]    r_state;
  logic [1:0]    r_idx;
  logic [TW-1:0] r_tries;
  logic [MW-1:0] r_match;
  logic [7:0]    r_prev;
  logic [15:0]   r_value;
  logic [3:0]    r_dp;
  logic [3:0]    r_blank;
  logic [3:0]    r_err;
  logic          r_valid;

  logic [7:0]    w_raw;
  logic [7:0]    w_samp;
  logic [TW-1:0] w_tries_n;
  logic [MW-1:0] w_match_n;
  logic [4:0]    w_dec;
  logic          w_blank;

  // Returns {ok, nibble}; the nibble is 0 for any unrecognised pattern.
  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1111110: r = 5'h10;
      7'b0110000: r = 5'h11;
      7'b1101101: r = 5'h12;
      7'b1111001: r = 5'h13;
      7'b0110011: r = 5'h14;
      7'b1011011: r = 5'h15;
      7'b1011111: r = 5'h16;
      7'b1110000: r = 5'h17;
      7'b1111111: r = 5'h18;
      7'b1111011: r = 5'h19;
      7'b1110111: r = 5'h1A;
      7'b0011111: r = 5'h1B;
      7'b1001110: r = 5'h1C;
      7'b0111101: r = 5'h1D;
      7'b1001111: r = 5'h1E;
      7'b1000111: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  // Bus bit 0 (segment a) lands in w_raw[7]; dp lands in w_raw[0].
  always_comb begin
    w_raw = LED4;
    case (r_idx)
      2'd0: w_raw = LED4;
      2'd1: w_raw = LED3;
      2'd2: w_raw = LED2;
      2'd3: w_raw = LED1;
      default: w_raw = LED4;
    endcase
  end

  always_comb begin
    w_samp    = Type ? ~w_raw : w_raw;
    w_tries_n = r_tries + 1'b1;
    w_match_n = MW'(1);
    if (r_match != '0 && w_samp == r_prev) w_match_n = r_match + 1'b1;
    w_dec   = f_decode(w_samp[7:1]);
    w_blank = (w_samp[7:1] == 7'b0000000);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_tries <= '0;
      r_match <= '0;
      r_prev  <= '0;
      r_value <= '0;
      r_dp    <= '0;
      r_blank <= '0;
      r_err   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start && En) begin
            r_idx   <= '0;
            r_tries <= '0;
            r_match <= '0;
            r_value <= '0;
            r_dp    <= '0;
            r_blank <= '0;
            r_err   <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_prev <= w_samp;
          if (w_match_n == L_STABLE || w_tries_n == L_MAX) begin
            // A stable match wins over a timeout landing on the same sample.
            if (w_match_n == L_STABLE) begin
              r_value[{r_idx, 2'b00} +: 4] <= w_dec[3:0];
              r_blank[r_idx]               <= w_blank;
              r_err[r_idx]                 <= !w_blank && !w_dec[4];
            end else begin
              r_value[{r_idx, 2'b00} +: 4] <= 4'h0;
              r_blank[r_idx]               <= 1'b0;
              r_err[r_idx]                 <= 1'b1;
            end
            r_dp[r_idx] <= w_samp[0];
            r_tries     <= '0;
            r_match     <= '0;
            r_idx       <= r_idx + 1'b1;
            if (r_idx == 2'd3) begin
              r_state <= S_DONE;
              r_valid <= 1'b1;
            end
          end else begin
            r_tries <= w_tries_n;
            r_match <= w_match_n;
          end
        end
        S_DONE: begin
          if (Ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Value       = r_value;
  assign DP          = r_dp;
  assign Blank       = r_blank;
  assign Err         = r_err;
  assign Valid       = r_valid;
  assign Busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seg7_display_reader.sv
// Directed bench for seg7_display_reader: decode, polarity, errors, timeouts,
// back-pressure, reset mid-scan and enable gating.
module tb_seg7_display_reader;

  localparam logic [6:0] P_0   = 7'b1111110;
  localparam logic [6:0] P_1   = 7'b0110000;
  localparam logic [6:0] P_2   = 7'b1101101;
  localparam logic [6:0] P_3   = 7'b1111001;
  localparam logic [6:0] P_9   = 7'b1111011;
  localparam logic [6:0] P_F   = 7'b1000111;
  localparam logic [6:0] P_BAD = 7'b1010101;
  localparam logic [6:0] P_OFF = 7'b0000000;

  logic        CLK = 1'b0;
  logic        Reset, Type, En, Start, Ready;
  logic [0:7]  LED1, LED2, LED3, LED4;
  logic [15:0] Value;
  logic [3:0]  DP, Blank, Err;
  logic        Valid, Busy;
  logic [1:0]  o_dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int lat;

  seg7_display_reader #(.STABLE(2), .MAX_TRIES(16)) dut (
    .CLK(CLK), .Reset(Reset), .Type(Type), .En(En), .Start(Start),
    .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4), .Ready(Ready),
    .Value(Value), .DP(DP), .Blank(Blank), .Err(Err), .Valid(Valid),
    .Busy(Busy), .o_dbg_state(o_dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_leds(input logic [6:0] s1, input logic [6:0] s2,
                          input logic [6:0] s3, input logic [6:0] s4);
    LED1 = {s1, 1'b0};
    LED2 = {s2, 1'b0};
    LED3 = {s3, 1'b0};
    LED4 = {s4, 1'b0};
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Counts edges after the accept edge until Valid; toggles LED4 between 1 and 2 if asked.
  task automatic wait_valid(input bit toggle, output int n);
    n = 0;
    while (Valid !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (toggle) LED4 = (LED4 == {P_1, 1'b0}) ? {P_2, 1'b0} : {P_1, 1'b0};
    end
  endtask

  initial begin
    Reset = 1'b1; Type = 1'b0; En = 1'b0; Start = 1'b0; Ready = 1'b0;
    set_leds(P_OFF, P_OFF, P_OFF, P_OFF);
    tick(); tick();
    Reset = 1'b0;
    chk("reset_value", 32'(Value), 32'h0);
    chk("reset_flags", 32'({DP, Blank, Err}), 32'h0);
    chk("reset_valid_busy", 32'({Valid, Busy}), 32'h0);
    chk("reset_state", 32'(o_dbg_state), 32'd0);

    // Basic read, active-high polarity
    En = 1'b1; Ready = 1'b1;
    set_leds(P_3, P_0, P_9, P_F);
    pulse_start();
    chk("t1_busy_on_accept", 32'(Busy), 32'd1);
    wait_valid(1'b0, lat);
    chk("t1_latency", 32'(lat), 32'd8);
    chk("t1_value", 32'(Value), 32'h309F);
    chk("t1_err_blank_dp", 32'({Err, Blank, DP}), 32'h0);
    tick();
    chk("t1_valid_drop", 32'({Valid, Busy}), 32'h0);

    // Inverted polarity; dp lit only on LED2
    Type = 1'b1;
    LED1 = ~{P_3, 1'b0};
    LED2 = {~P_0, 1'b0};
    LED3 = ~{P_9, 1'b0};
    LED4 = ~{P_F, 1'b0};
    pulse_start();
    Type = 1'b0;
    Type = 1'b1;
    wait_valid(1'b0, lat);
    chk("t2_latency", 32'(lat), 32'd8);
    chk("t2_value", 32'(Value), 32'h309F);
    chk("t2_dp", 32'(DP), 32'b0100);
    chk("t2_err_blank", 32'({Err, Blank}), 32'h0);
    tick();

    // Invalid pattern on LED3, blank LED4
    Type = 1'b0;
    set_leds(P_3, P_0, P_BAD, P_OFF);
    pulse_start();
    wait_valid(1'b0, lat);
    chk("t3_err", 32'(Err), 32'b0010);
    chk("t3_blank", 32'(Blank), 32'b0001);
    chk("t3_low_nibbles", 32'(Value[7:0]), 32'h00);
    chk("t3_value", 32'(Value), 32'h3000);
    tick();

    // LED4 never settles: timeout on digit 0
    set_leds(P_3, P_0, P_9, P_1);
    pulse_start();
    wait_valid(1'b1, lat);
    chk("t4_latency", 32'(lat), 32'd22);
    chk("t4_value", 32'(Value), 32'h3090);
    chk("t4_err", 32'(Err), 32'b0001);
    chk("t4_blank_dp", 32'({Blank, DP}), 32'h0);
    tick();

    // Back-pressure: result frozen, Start ignored in DONE
    Ready = 1'b0;
    set_leds(P_3, P_0, P_9, P_F);
    pulse_start();
    wait_valid(1'b0, lat);
    chk("t5_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      set_leds(P_1, P_2, P_BAD, P_OFF);
      Start = 1'b1;
      tick();
      chk("t5_hold_valid", 32'({Valid, Busy}), 32'h3);
      chk("t5_hold_value", 32'(Value), 32'h309F);
      chk("t5_hold_err", 32'(Err), 32'h0);
    end
    set_leds(P_3, P_0, P_9, P_F);
    Ready = 1'b1;
    tick();
    chk("t5_handshake", 32'({Valid, Busy}), 32'h0);
    chk("t5_state_idle", 32'(o_dbg_state), 32'd0);
    tick();
    Start = 1'b0;
    chk("t5_start_next_cycle", 32'(Busy), 32'd1);
    wait_valid(1'b0, lat);
    chk("t5_relatency", 32'(lat), 32'd8);
    chk("t5_revalue", 32'(Value), 32'h309F);
    tick();

    // Reset in the middle of digit index 2
    pulse_start();
    tick(); tick(); tick(); tick();
    chk("t6_partial_value", 32'(Value), 32'h009F);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("t6_reset_value", 32'(Value), 32'h0);
    chk("t6_reset_flags", 32'({DP, Blank, Err, Valid, Busy}), 32'h0);
    chk("t6_reset_state", 32'(o_dbg_state), 32'd0);
    set_leds(P_9, P_F, P_3, P_0);
    pulse_start();
    wait_valid(1'b0, lat);
    chk("t6_fresh_latency", 32'(lat), 32'd8);
    chk("t6_fresh_value", 32'(Value), 32'h9F30);
    tick();

    // En low blocks Start
    En = 1'b0;
    Start = 1'b1;
    tick();
    chk("t7_en_low_busy", 32'(Busy), 32'd0);
    tick();
    Start = 1'b0;
    chk("t7_en_low_busy2", 32'({Busy, Valid}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
